// File: rtl/ahb3lite_arb2.sv
// Two-requester round-robin front end driving a single AHB3-Lite master port.
// One transfer outstanding at a time; every output comes straight from a flop.
module ahb3lite_arb2 #(
    parameter int HADDR_SIZE = 16,
    parameter int HDATA_SIZE = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,

    input  logic                  r0_req,
    input  logic [HADDR_SIZE-1:0] r0_addr,
    input  logic                  r0_write,
    input  logic [2:0]            r0_size,
    input  logic [HDATA_SIZE-1:0] r0_wdata,
    output logic                  r0_ack,
    output logic                  r0_err,

    input  logic                  r1_req,
    input  logic [HADDR_SIZE-1:0] r1_addr,
    input  logic                  r1_write,
    input  logic [2:0]            r1_size,
    input  logic [HDATA_SIZE-1:0] r1_wdata,
    output logic                  r1_ack,
    output logic                  r1_err,

    output logic [HDATA_SIZE-1:0] rdata,
    output logic                  busy,

    output logic                  HSEL,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic [HDATA_SIZE-1:0] HWDATA,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADDR    = 2'd1,
        S_DATA    = 2'd2,
        S_ERRDONE = 2'd3
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  gnt_q, gnt_d;
    logic                  busy_q, busy_d;
    logic                  hsel_q, hsel_d;
    logic [1:0]            htrans_q, htrans_d;
    logic [HADDR_SIZE-1:0] haddr_q, haddr_d;
    logic                  hwrite_q, hwrite_d;
    logic [2:0]            hsize_q, hsize_d;
    logic [HDATA_SIZE-1:0] wdata_q, wdata_d;
    logic [HDATA_SIZE-1:0] hwdata_q, hwdata_d;
    logic [HDATA_SIZE-1:0] rdata_q, rdata_d;
    logic                  ack0_q, ack0_d, ack1_q, ack1_d;
    logic                  err0_q, err0_d, err1_q, err1_d;

    logic                  el0, el1, pick;
    logic [HADDR_SIZE-1:0] sel_addr;
    logic                  sel_write;
    logic [2:0]            sel_size;
    logic [HDATA_SIZE-1:0] sel_wdata;

    // Illegal HSIZE for this bus width, or address not aligned to the transfer size.
    function automatic logic bad_xfer(input logic [1:0] a_lo, input logic [2:0] sz);
        logic bad;
        case (sz)
            3'd0:    bad = 1'b0;
            3'd1:    bad = a_lo[0];
            3'd2:    bad = |a_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        hsel_d   = hsel_q;
        htrans_d = htrans_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        wdata_d  = wdata_q;
        hwdata_d = hwdata_q;
        rdata_d  = rdata_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;

        // A requester whose ack is showing this cycle has not yet had a chance to drop req.
        el0  = r0_req && !ack0_q;
        el1  = r1_req && !ack1_q;
        pick = el1 && (!el0 || !last_q);

        sel_addr  = pick ? r1_addr  : r0_addr;
        sel_write = pick ? r1_write : r0_write;
        sel_size  = pick ? r1_size  : r0_size;
        sel_wdata = pick ? r1_wdata : r0_wdata;

        case (state_q)
            S_IDLE: begin
                if (el0 || el1) begin
                    gnt_d    = pick;
                    last_d   = pick;
                    haddr_d  = sel_addr;
                    hwrite_d = sel_write;
                    hsize_d  = sel_size;
                    wdata_d  = sel_wdata;
                    if (bad_xfer(sel_addr[1:0], sel_size)) begin
                        state_d = S_ERRDONE;
                    end else begin
                        state_d  = S_ADDR;
                        hsel_d   = 1'b1;
                        htrans_d = TR_NONSEQ;
                    end
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    state_d  = S_DATA;
                    hsel_d   = 1'b0;
                    htrans_d = TR_IDLE;
                    if (hwrite_q) begin
                        hwdata_d = wdata_q;
                    end
                end
            end
            S_DATA: begin
                // An ERROR response keeps HREADY low for its first cycle, so it is simply waited out.
                if (HREADY) begin
                    state_d = S_IDLE;
                    ack0_d  = !gnt_q;
                    ack1_d  = gnt_q;
                    err0_d  = !gnt_q && HRESP;
                    err1_d  = gnt_q && HRESP;
                    if (!hwrite_q) begin
                        rdata_d = HRDATA;
                    end
                end
            end
            S_ERRDONE: begin
                state_d = S_IDLE;
                ack0_d  = !gnt_q;
                ack1_d  = gnt_q;
                err0_d  = !gnt_q;
                err1_d  = gnt_q;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            busy_q   <= 1'b0;
            hsel_q   <= 1'b0;
            htrans_q <= TR_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= 3'd0;
            hwdata_q <= '0;
            rdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            hsel_q   <= hsel_d;
            htrans_q <= htrans_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
        end
    end

    always_ff @(posedge HCLK) begin
        wdata_q <= wdata_d;
    end

    assign r0_ack = ack0_q;
    assign r0_err = err0_q;
    assign r1_ack = ack1_q;
    assign r1_err = err1_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;
    assign HSEL   = hsel_q;
    assign HADDR  = haddr_q;
    assign HWRITE = hwrite_q;
    assign HSIZE  = hsize_q;
    assign HBURST = 3'b000;
    assign HPROT  = 4'b0011;
    assign HTRANS = htrans_q;
    assign HWDATA = hwdata_q;

endmodule

// File: tb/tb_ahb3lite_arb2.sv
// Directed bench for ahb3lite_arb2: stimulus pushes expected completions, a monitor pops them on each ack.
module tb_ahb3lite_arb2;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        r0_req = 0, r0_write = 0, r1_req = 0, r1_write = 0;
    logic [15:0] r0_addr = 0, r1_addr = 0;
    logic [2:0]  r0_size = 0, r1_size = 0;
    logic [31:0] r0_wdata = 0, r1_wdata = 0;
    logic        r0_ack, r0_err, r1_ack, r1_err, busy;
    logic [31:0] rdata, HWDATA;
    logic        HSEL, HWRITE;
    logic [15:0] HADDR;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic [31:0] HRDATA = 0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    typedef struct packed {
        logic        id;
        logic        err;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    ahb3lite_arb2 #(.HADDR_SIZE(16), .HDATA_SIZE(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_write(r0_write), .r0_size(r0_size),
        .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_err(r0_err),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_write(r1_write), .r1_size(r1_size),
        .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_err(r1_err),
        .rdata(rdata), .busy(busy),
        .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    function automatic exp_t mk(input logic id, input logic err, input logic rd, input logic [31:0] d);
        exp_t e;
        e.id = id; e.err = err; e.rd = rd; e.data = d;
        return e;
    endfunction

    // Monitor: every ack must match the oldest queued expectation.
    logic prev0 = 0, prev1 = 0;
    always @(negedge HCLK) begin
        if (r0_ack || r1_ack) begin
            exp_t e;
            chk("ack_onehot", {63'd0, r0_ack & r1_ack}, 64'd0);
            chk("no_b2b_ack", {63'd0, (r0_ack & prev0) | (r1_ack & prev1)}, 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", {62'd0, r1_ack, r0_ack}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_id", {63'd0, r1_ack}, {63'd0, e.id});
                chk("ack_err", {63'd0, (e.id ? r1_err : r0_err)}, {63'd0, e.err});
                if (e.rd) chk("ack_rdata", {32'd0, rdata}, {32'd0, e.data});
            end
        end
        prev0 <= r0_ack;
        prev1 <= r1_ack;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        HRESET = 1'b1;
        tick();
        tick();
        HRESET = 1'b0;
    endtask

    initial begin
        int n0, n1;

        // Reset state
        do_reset();
        HRESET = 1'b1;
        tick();
        chk("rst_hsel",   {63'd0, HSEL}, 64'd0);
        chk("rst_htrans", {62'd0, HTRANS}, 64'd0);
        chk("rst_haddr",  {48'd0, HADDR}, 64'd0);
        chk("rst_hwrite", {63'd0, HWRITE}, 64'd0);
        chk("rst_hsize",  {61'd0, HSIZE}, 64'd0);
        chk("rst_hburst", {61'd0, HBURST}, 64'd0);
        chk("rst_hprot",  {60'd0, HPROT}, 64'd3);
        chk("rst_hwdata", {32'd0, HWDATA}, 64'd0);
        chk("rst_rdata",  {32'd0, rdata}, 64'd0);
        chk("rst_acks",   {60'd0, r0_ack, r0_err, r1_ack, r1_err}, 64'd0);
        chk("rst_busy",   {63'd0, busy}, 64'd0);
        HRESET = 1'b0;

        // Zero-wait single write from r0
        r0_req = 1; r0_addr = 16'h0010; r0_write = 1; r0_size = 3'd2; r0_wdata = 32'hDEADBEEF;
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0));
        tick();
        chk("wr_htrans_c1", {62'd0, HTRANS}, 64'd2);
        chk("wr_hsel_c1",   {63'd0, HSEL}, 64'd1);
        chk("wr_haddr_c1",  {48'd0, HADDR}, 64'h0010);
        chk("wr_ctrl_c1",   {56'd0, HWRITE, HSIZE, HBURST, busy}, {56'd0, 1'b1, 3'd2, 3'd0, 1'b1});
        chk("wr_hprot_c1",  {60'd0, HPROT}, 64'd3);
        r0_addr = 16'hFFFF; r0_wdata = 32'h0;
        tick();
        chk("wr_htrans_c2", {62'd0, HTRANS}, 64'd0);
        chk("wr_hsel_c2",   {63'd0, HSEL}, 64'd0);
        chk("wr_hwdata_c2", {32'd0, HWDATA}, 64'hDEADBEEF);
        tick();
        chk("wr_ack_c3",    {62'd0, r0_ack, r0_err}, 64'd2);
        r0_req = 0;
        tick();
        chk("wr_idle_after", {62'd0, busy, r0_ack}, 64'd0);

        // Read from r1 with three data-phase wait states
        r1_req = 1; r1_addr = 16'h0020; r1_write = 0; r1_size = 3'd2;
        sb.push_back(mk(1'b1, 1'b0, 1'b1, 32'h12345678));
        tick();
        chk("rd_nonseq", {46'd0, HTRANS, HADDR}, {46'd0, 2'b10, 16'h0020});
        tick();
        HREADY = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd_wait", {62'd0, r1_ack, busy}, 64'd1);
        end
        HREADY = 1; HRDATA = 32'h12345678;
        tick();
        chk("rd_ack", {63'd0, r1_ack}, 64'd1);
        chk("rd_rdata", {32'd0, rdata}, 64'h12345678);
        r1_req = 0; HRDATA = 32'h0;
        tick();
        chk("rd_rdata_hold", {32'd0, rdata}, 64'h12345678);

        // Misaligned word from r1: no bus transfer, error ack
        r1_req = 1; r1_addr = 16'h0003; r1_size = 3'd2;
        sb.push_back(mk(1'b1, 1'b1, 1'b0, 32'd0));
        tick();
        chk("mis_no_bus", {61'd0, HTRANS, HSEL, busy}, 64'd1);
        tick();
        chk("mis_ack", {60'd0, r1_ack, r1_err, HTRANS}, {60'd0, 2'b11, 2'b00});
        r1_req = 0;
        tick();

        // Oversized HSIZE from r0
        r0_req = 1; r0_addr = 16'h0000; r0_write = 0; r0_size = 3'd3;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 32'd0));
        tick();
        chk("big_no_bus", {62'd0, HTRANS}, 64'd0);
        tick();
        chk("big_ack", {62'd0, r0_ack, r0_err}, 64'd3);
        r0_req = 0;
        tick();

        // Two-cycle slave ERROR on a halfword write
        r0_req = 1; r0_addr = 16'h0042; r0_write = 1; r0_size = 3'd1; r0_wdata = 32'h000055AA;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 32'd0));
        tick();
        chk("err_nonseq", {62'd0, HTRANS}, 64'd2);
        tick();
        chk("err_hwdata", {32'd0, HWDATA}, 64'h000055AA);
        HREADY = 0; HRESP = 1;
        tick();
        chk("err_wait", {62'd0, r0_ack, busy}, 64'd1);
        HREADY = 1; HRESP = 1;
        tick();
        chk("err_ack", {62'd0, r0_ack, r0_err}, 64'd3);
        chk("err_rdata_kept", {32'd0, rdata}, 64'h12345678);
        HRESP = 0; r0_req = 0;
        tick();

        // Continuous contention from reset: r0, r1, r0, r1
        do_reset();
        r0_addr = 16'h0100; r0_write = 1; r0_size = 3'd2; r0_wdata = 32'h11112222;
        r1_addr = 16'h0200; r1_write = 0; r1_size = 3'd2;
        HRDATA = 32'hA5A50001;
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0));
        sb.push_back(mk(1'b1, 1'b0, 1'b1, 32'hA5A50001));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0));
        sb.push_back(mk(1'b1, 1'b0, 1'b1, 32'hA5A50001));
        r0_req = 1; r1_req = 1;
        n0 = 0; n1 = 0;
        for (int c = 0; c < 40 && !(n0 == 2 && n1 == 2); c++) begin
            tick();
            if (r0_ack) begin n0++; if (n0 == 2) r0_req = 0; end
            if (r1_ack) begin n1++; if (n1 == 2) r1_req = 0; end
        end
        r0_req = 0; r1_req = 0; HRDATA = 32'h0;
        chk("cont_counts", {32'd0, n0[15:0], n1[15:0]}, {32'd0, 16'd2, 16'd2});
        tick();

        // Reset while the address phase is stalled
        r1_req = 1; r1_addr = 16'h0080; r1_write = 1; r1_size = 3'd2; r1_wdata = 32'hCAFEF00D;
        tick();
        chk("rst_mid_nonseq", {62'd0, HTRANS}, 64'd2);
        HREADY = 0;
        tick();
        chk("rst_mid_held", {62'd0, HTRANS}, 64'd2);
        HRESET = 1; r1_req = 0;
        tick();
        chk("rst_mid_abort", {60'd0, HTRANS, busy, HSEL}, 64'd0);
        HRESET = 0; HREADY = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_mid_no_ack_busy", {63'd0, busy}, 64'd0);

        chk("sb_drained", sb.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
